// File: rtl/mem_stage_pkg.sv
// Shared widths, address map and FSM encodings for the memory-access stage.
package mem_stage_pkg;

    localparam int REGISTER_LEN    = 32;
    localparam int ADDRESS_LEN     = 32;
    localparam int REG_ADDRESS_LEN = 4;
    localparam int SRAM_ADDR_WIDTH = 18;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int DATA_BASE       = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// External SRAM pin bundle: master drives address/data/strobe, slave returns read data.
interface mem_stage_if #(
    parameter int ADDR_W = mem_stage_pkg::SRAM_ADDR_WIDTH,
    parameter int DATA_W = mem_stage_pkg::SRAM_DATA_WIDTH
);
    // No valid/ready: the master holds sram_addr (and sram_we_n/sram_wdata) stable for
    // WAIT_CYCLES cycles per halfword; sram_rdata is valid while the address is held.
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_we_n;

    modport master (output sram_addr, sram_wdata, sram_we_n, input sram_rdata);
    modport slave  (input sram_addr, sram_wdata, sram_we_n, output sram_rdata);
endinterface

// File: rtl/mem_stage_sram_controller.sv
// Splits each 32-bit load/store into a LOW and a HIGH halfword access, each held
// WAIT_CYCLES cycles, and stalls upstream until the final access cycle.
module sram_controller
    import mem_stage_pkg::state_t, mem_stage_pkg::IDLE, mem_stage_pkg::LOW, mem_stage_pkg::HIGH;
#(
    parameter int REGISTER_LEN    = mem_stage_pkg::REGISTER_LEN,
    parameter int SRAM_ADDR_WIDTH = mem_stage_pkg::SRAM_ADDR_WIDTH,
    parameter int SRAM_DATA_WIDTH = mem_stage_pkg::SRAM_DATA_WIDTH,
    parameter int WAIT_CYCLES     = 3,
    parameter int DATA_BASE       = mem_stage_pkg::DATA_BASE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_r_en,
    input  logic                    mem_w_en,
    input  logic [REGISTER_LEN-1:0] addr,
    input  logic [REGISTER_LEN-1:0] wdata_word,
    mem_stage_if.master             sram,
    output logic                    freeze,
    output logic                    done,
    output logic                    op_write,
    output logic [REGISTER_LEN-1:0] rd_word,
    output state_t                  fsm_state
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int BW = SRAM_ADDR_WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    state_t                   state, state_nxt, eff;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [BW-1:0]            base_q, base_cur;
    logic [REGISTER_LEN-1:0]  data_q, data_cur, off;
    logic [SRAM_DATA_WIDTH-1:0] low_q;
    logic                     wr_q, wr_cur, req, start, active, last, phase;
    logic                     unused_off;

    assign req        = mem_r_en | mem_w_en;
    assign off        = addr - REGISTER_LEN'(DATA_BASE);
    assign unused_off = ^{off[1:0], off[REGISTER_LEN-1:SRAM_ADDR_WIDTH+1]};
    // The first access cycle is served straight from the inputs, before the latch fills.
    assign start      = rst && (state == IDLE) && req;

    always_comb begin
        eff       = start ? LOW : state;
        active    = rst && (eff != IDLE);
        last      = (cnt == LAST);
        phase     = (eff == HIGH);
        base_cur  = start ? off[SRAM_ADDR_WIDTH:2] : base_q;
        data_cur  = start ? wdata_word : data_q;
        wr_cur    = start ? mem_w_en : wr_q;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (eff)
            LOW: begin
                state_nxt = last ? HIGH : LOW;
                cnt_nxt   = last ? '0 : cnt + 1'b1;
            end
            HIGH: begin
                state_nxt = last ? IDLE : HIGH;
                cnt_nxt   = last ? '0 : cnt + 1'b1;
            end
            default: ;
        endcase
        freeze          = active && !(phase && last);
        done            = active && phase && last;
        op_write        = wr_cur;
        sram.sram_addr  = '0;
        sram.sram_wdata = '0;
        sram.sram_we_n  = 1'b1;
        if (active) begin
            sram.sram_addr  = {base_cur, phase};
            sram.sram_wdata = phase ? data_cur[REGISTER_LEN-1:SRAM_DATA_WIDTH]
                                    : data_cur[SRAM_DATA_WIDTH-1:0];
            sram.sram_we_n  = !wr_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            base_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
            low_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                base_q <= off[SRAM_ADDR_WIDTH:2];
                data_q <= wdata_word;
                wr_q   <= mem_w_en;
            end
            if ((eff == LOW) && last && !wr_cur) low_q <= sram.sram_rdata;
        end
    end

    assign rd_word   = {sram.sram_rdata, low_q};
    assign fsm_state = state;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: SRAM access sequencing plus the MEM/WB pipeline register feeding write-back.
module mem_stage
    import mem_stage_pkg::state_t;
#(
    parameter int REGISTER_LEN    = mem_stage_pkg::REGISTER_LEN,
    parameter int REG_ADDRESS_LEN = mem_stage_pkg::REG_ADDRESS_LEN,
    parameter int SRAM_ADDR_WIDTH = mem_stage_pkg::SRAM_ADDR_WIDTH,
    parameter int SRAM_DATA_WIDTH = mem_stage_pkg::SRAM_DATA_WIDTH,
    parameter int WAIT_CYCLES     = 3,
    parameter int DATA_BASE       = mem_stage_pkg::DATA_BASE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_en_in,
    input  logic                       mem_r_en_in,
    input  logic                       mem_w_en_in,
    input  logic [REGISTER_LEN-1:0]    alu_res_in,
    input  logic [REGISTER_LEN-1:0]    val_Rm_in,
    input  logic [REG_ADDRESS_LEN-1:0] dest_in,
    output logic                       freeze,
    mem_stage_if.master                sram,
    output logic                       wb_en_out,
    output logic                       mem_r_en_out,
    output logic [REGISTER_LEN-1:0]    alu_res_out,
    output logic [REGISTER_LEN-1:0]    mem_data_out,
    output logic [REG_ADDRESS_LEN-1:0] dest_out,
    output state_t                     fsm_state
);
    logic                    done, op_write;
    logic [REGISTER_LEN-1:0] rd_word;

    sram_controller #(
        .REGISTER_LEN   (REGISTER_LEN),
        .SRAM_ADDR_WIDTH(SRAM_ADDR_WIDTH),
        .SRAM_DATA_WIDTH(SRAM_DATA_WIDTH),
        .WAIT_CYCLES    (WAIT_CYCLES),
        .DATA_BASE      (DATA_BASE)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .mem_r_en  (mem_r_en_in),
        .mem_w_en  (mem_w_en_in),
        .addr      (alu_res_in),
        .wdata_word(val_Rm_in),
        .sram      (sram),
        .freeze    (freeze),
        .done      (done),
        .op_write  (op_write),
        .rd_word   (rd_word),
        .fsm_state (fsm_state)
    );

    // Upstream is frozen during an access, so the inputs still describe the same op at completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            alu_res_out  <= '0;
            mem_data_out <= '0;
            dest_out     <= '0;
        end else begin
            if (!freeze) begin
                wb_en_out    <= wb_en_in;
                mem_r_en_out <= mem_r_en_in;
                alu_res_out  <= alu_res_in;
                dest_out     <= dest_in;
            end
            if (done && !op_write) mem_data_out <= rd_word;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: random loads/stores against a word-level memory model,
// plus ALU pass-through, back-to-back, conflict, reset abort and single-wait-state cases.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int W    = 3;
    localparam int NMAX = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // main DUT (W=3)
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_res_in, val_Rm_in;
    logic [3:0]  dest_in;
    logic        freeze, wb_en_out, mem_r_en_out;
    logic [31:0] alu_res_out, mem_data_out;
    logic [3:0]  dest_out;
    state_t      fsm_state;

    // second DUT (W=1)
    logic        w1_wb_en_in, w1_mem_r_en_in, w1_mem_w_en_in;
    logic [31:0] w1_alu_res_in, w1_val_Rm_in;
    logic [3:0]  w1_dest_in;
    logic        w1_freeze, w1_wb_en_out, w1_mem_r_en_out;
    logic [31:0] w1_alu_res_out, w1_mem_data_out;
    logic [3:0]  w1_dest_out;
    state_t      w1_fsm_state;

    mem_stage_if sif ();
    mem_stage_if sif1 ();

    logic [15:0] sram  [0:(1<<18)-1];
    logic [15:0] sram1 [0:(1<<18)-1];
    assign sif.sram_rdata  = sram[sif.sram_addr];
    assign sif1.sram_rdata = sram1[sif1.sram_addr];
    always @(posedge clk) if (!sif.sram_we_n)  sram[sif.sram_addr]   <= sif.sram_wdata;
    always @(posedge clk) if (!sif1.sram_we_n) sram1[sif1.sram_addr] <= sif1.sram_wdata;

    mem_stage #(.WAIT_CYCLES(W), .DATA_BASE(1024)) dut (
        .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in),
        .dest_in(dest_in), .freeze(freeze), .sram(sif), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
        .mem_data_out(mem_data_out), .dest_out(dest_out), .fsm_state(fsm_state)
    );

    mem_stage #(.WAIT_CYCLES(1), .DATA_BASE(1024)) dut_w1 (
        .clk(clk), .rst(rst), .wb_en_in(w1_wb_en_in), .mem_r_en_in(w1_mem_r_en_in),
        .mem_w_en_in(w1_mem_w_en_in), .alu_res_in(w1_alu_res_in), .val_Rm_in(w1_val_Rm_in),
        .dest_in(w1_dest_in), .freeze(w1_freeze), .sram(sif1), .wb_en_out(w1_wb_en_out),
        .mem_r_en_out(w1_mem_r_en_out), .alu_res_out(w1_alu_res_out),
        .mem_data_out(w1_mem_data_out), .dest_out(w1_dest_out), .fsm_state(w1_fsm_state)
    );

    // reference model: 32-bit words indexed by word number within the wrapped SRAM window
    logic [31:0] ref_words [int unsigned];
    int unsigned addr_list [$];
    logic [31:0] exp_q [$];
    logic [31:0] last_load = '0;

    // per-cycle observations of the op in flight
    logic [17:0] a_log [$];
    logic [15:0] d_log [$];
    logic        we_log [$];
    logic        f_log [$];
    int          first_cyc, last_cyc;

    function automatic int unsigned word_idx(input logic [31:0] a);
        int unsigned off;
        off = a - 32'd1024;
        return (off / 4) % 131072;
    endfunction

    function automatic logic [17:0] exp_haddr(input logic [31:0] a, input int k);
        return 18'(word_idx(a) * 2 + ((k >= W) ? 1 : 0));
    endfunction

    function automatic logic [15:0] exp_half(input logic [31:0] v, input int k);
        return (k >= W) ? v[31:16] : v[15:0];
    endfunction

    task automatic idle();
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        alu_res_in = '0; val_Rm_in = '0; dest_in = '0;
    endtask

    task automatic idle_w1();
        w1_wb_en_in = 0; w1_mem_r_en_in = 0; w1_mem_w_en_in = 0;
        w1_alu_res_in = '0; w1_val_Rm_in = '0; w1_dest_in = '0;
    endtask

    // Presents one op and records pins each cycle until freeze drops; returns just after the completion edge.
    task automatic drive_op(input logic r, input logic w, input logic wb, input logic [31:0] a,
                            input logic [31:0] v, input logic [3:0] d, output int n);
        wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
        alu_res_in = a; val_Rm_in = v; dest_in = d;
        a_log.delete(); d_log.delete(); we_log.delete(); f_log.delete();
        n = 0;
        for (int k = 0; k < NMAX; k++) begin
            @(negedge clk);
            if (k == 0) first_cyc = cyc;
            last_cyc = cyc;
            a_log.push_back(sif.sram_addr);
            d_log.push_back(sif.sram_wdata);
            we_log.push_back(sif.sram_we_n);
            f_log.push_back(freeze);
            n++;
            if (!freeze) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 0; idle(); idle_w1();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (freeze !== 1'b0 || sif.sram_we_n !== 1'b1) begin errors++;
            $display("FAIL reset_pins freeze=%b we_n=%b exp 0/1", freeze, sif.sram_we_n); end
        checks++; if ({wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out} !== '0) begin errors++;
            $display("FAIL reset_outs got=%h exp=0", {wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out}); end
        checks++; if (fsm_state !== IDLE) begin errors++;
            $display("FAIL reset_state got=%0d exp=%0d", fsm_state, IDLE); end
        checks++; if ({w1_freeze, w1_wb_en_out, w1_alu_res_out, w1_mem_data_out, w1_dest_out} !== '0) begin errors++;
            $display("FAIL reset_w1_outs got=%h exp=0", {w1_freeze, w1_wb_en_out, w1_alu_res_out, w1_mem_data_out}); end
        rst = 1;
    endtask

    task automatic test_alu_op();
        logic [31:0] a; logic [3:0] d; logic wb;
        for (int t = 0; t < 4; t++) begin
            a  = (t == 0) ? 32'd7 : $urandom;
            d  = (t == 0) ? 4'd3 : 4'($urandom_range(0, 15));
            wb = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wb_en_in = wb; alu_res_in = a; dest_in = d; val_Rm_in = $urandom;
            @(negedge clk);
            checks++; if (freeze !== 1'b0 || sif.sram_we_n !== 1'b1 || sif.sram_addr !== '0 || sif.sram_wdata !== '0) begin
                errors++; $display("FAIL alu_pins t=%0d freeze=%b we_n=%b addr=%h wdata=%h exp 0/1/0/0",
                                   t, freeze, sif.sram_we_n, sif.sram_addr, sif.sram_wdata); end
            @(posedge clk); #1;
            checks++; if (alu_res_out !== a || dest_out !== d || wb_en_out !== wb || mem_r_en_out !== 1'b0) begin
                errors++; $display("FAIL alu_wb t=%0d got=%h/%h/%b/%b exp=%h/%h/%b/0",
                                   t, alu_res_out, dest_out, wb_en_out, mem_r_en_out, a, d, wb); end
            checks++; if (mem_data_out !== last_load) begin
                errors++; $display("FAIL alu_memdata got=%h exp=%h", mem_data_out, last_load); end
        end
        idle();
    endtask

    task automatic test_store();
        logic [31:0] a, v; int n;
        for (int t = 0; t < 4; t++) begin
            a = (t == 0) ? 32'd1032 : 32'd1024 + 32'(4 * $urandom_range(16, 4095));
            v = (t == 0) ? 32'hDEADBEEF : $urandom;
            drive_op(1'b0, 1'b1, 1'b0, a, v, 4'(t), n);
            idle();
            checks++; if (n != 2 * W) begin errors++; $display("FAIL store_len got=%0d exp=%0d", n, 2 * W); end
            for (int k = 0; k < a_log.size(); k++) begin
                checks++;
                if (a_log[k] !== exp_haddr(a, k) || d_log[k] !== exp_half(v, k) || we_log[k] !== 1'b0 ||
                    f_log[k] !== (k < 2 * W - 1)) begin
                    errors++; $display("FAIL store_pins k=%0d got=%h/%h/%b/%b exp=%h/%h/0/%b", k, a_log[k], d_log[k],
                                       we_log[k], f_log[k], exp_haddr(a, k), exp_half(v, k), (k < 2 * W - 1));
                end
            end
            checks++; if (alu_res_out !== a || mem_r_en_out !== 1'b0 || dest_out !== 4'(t)) begin errors++;
                $display("FAIL store_wb got=%h/%b/%h exp=%h/0/%h", alu_res_out, mem_r_en_out, dest_out, a, 4'(t)); end
            ref_words[word_idx(a)] = v;
            addr_list.push_back(a);
        end
    endtask

    task automatic test_load();
        logic [31:0] a, got; logic [3:0] d; int n;
        for (int t = 0; t < 5; t++) begin
            a = (t == 0) ? 32'd1032 : addr_list[$urandom_range(0, addr_list.size() - 1)] + 32'($urandom_range(0, 3));
            d = 4'($urandom_range(1, 15));
            exp_q.push_back(ref_words[word_idx(a)]);
            drive_op(1'b1, 1'b0, 1'b1, a, $urandom, d, n);
            idle();
            got = exp_q.pop_front();
            checks++; if (n != 2 * W) begin errors++; $display("FAIL load_len got=%0d exp=%0d", n, 2 * W); end
            for (int k = 0; k < a_log.size(); k++) begin
                checks++;
                if (a_log[k] !== exp_haddr(a, k) || we_log[k] !== 1'b1 || f_log[k] !== (k < 2 * W - 1)) begin
                    errors++; $display("FAIL load_pins k=%0d got=%h/%b/%b exp=%h/1/%b", k, a_log[k], we_log[k],
                                       f_log[k], exp_haddr(a, k), (k < 2 * W - 1));
                end
            end
            checks++; if (mem_data_out !== got || mem_r_en_out !== 1'b1 || dest_out !== d || wb_en_out !== 1'b1) begin
                errors++; $display("FAIL load_wb got=%h/%b/%h/%b exp=%h/1/%h/1", mem_data_out, mem_r_en_out,
                                   dest_out, wb_en_out, got, d); end
            if (t == 0) begin
                checks++; if (mem_data_out !== 32'hDEADBEEF) begin errors++;
                    $display("FAIL load_spec got=%h exp=deadbeef", mem_data_out); end
            end
            last_load = got;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, a2, v2, got; int n1, n2, lc;
        a1 = addr_list[$urandom_range(0, addr_list.size() - 1)];
        a2 = 32'd1024 + 32'(4 * $urandom_range(16, 4095));
        v2 = $urandom;
        exp_q.push_back(ref_words[word_idx(a1)]);
        drive_op(1'b1, 1'b0, 1'b1, a1, '0, 4'd9, n1);
        lc = last_cyc;
        got = exp_q.pop_front();
        checks++; if (mem_data_out !== got) begin errors++; $display("FAIL b2b_load got=%h exp=%h", mem_data_out, got); end
        last_load = got;
        drive_op(1'b0, 1'b1, 1'b0, a2, v2, 4'd2, n2);
        idle();
        checks++; if (first_cyc != lc + 1) begin errors++;
            $display("FAIL b2b_gap start=%0d exp=%0d", first_cyc, lc + 1); end
        checks++; if (n1 != 2 * W || n2 != 2 * W) begin errors++;
            $display("FAIL b2b_len got=%0d/%0d exp=%0d", n1, n2, 2 * W); end
        for (int k = 0; k < a_log.size(); k++) begin
            checks++;
            if (a_log[k] !== exp_haddr(a2, k) || d_log[k] !== exp_half(v2, k) || we_log[k] !== 1'b0) begin
                errors++; $display("FAIL b2b_store k=%0d got=%h/%h/%b exp=%h/%h/0", k, a_log[k], d_log[k],
                                   we_log[k], exp_haddr(a2, k), exp_half(v2, k));
            end
        end
        ref_words[word_idx(a2)] = v2;
        addr_list.push_back(a2);
    endtask

    task automatic test_conflict();
        logic [31:0] a, v, got; int n;
        a = 32'd1024 + 32'(4 * $urandom_range(16, 4095));
        v = $urandom | 32'h1;
        drive_op(1'b1, 1'b1, 1'b1, a, v, 4'd6, n);
        idle();
        checks++; if (n != 2 * W) begin errors++; $display("FAIL conflict_len got=%0d exp=%0d", n, 2 * W); end
        for (int k = 0; k < we_log.size(); k++) begin
            checks++;
            if (we_log[k] !== 1'b0 || d_log[k] !== exp_half(v, k)) begin
                errors++; $display("FAIL conflict_write k=%0d got=%b/%h exp=0/%h", k, we_log[k], d_log[k], exp_half(v, k));
            end
        end
        checks++; if (mem_data_out !== last_load) begin errors++;
            $display("FAIL conflict_memdata got=%h exp=%h", mem_data_out, last_load); end
        ref_words[word_idx(a)] = v;
        exp_q.push_back(ref_words[word_idx(a)]);
        drive_op(1'b1, 1'b0, 1'b1, a, '0, 4'd7, n);
        idle();
        got = exp_q.pop_front();
        checks++; if (mem_data_out !== got) begin errors++;
            $display("FAIL conflict_readback got=%h exp=%h", mem_data_out, got); end
        last_load = got;
    endtask

    task automatic test_reset_mid();
        wb_en_in = 1; mem_w_en_in = 1; alu_res_in = 32'd1024 + 32'd20000; val_Rm_in = $urandom; dest_in = 4'd11;
        @(negedge clk);
        checks++; if (freeze !== 1'b1 || sif.sram_we_n !== 1'b0) begin errors++;
            $display("FAIL rstmid_k0 freeze=%b we_n=%b exp 1/0", freeze, sif.sram_we_n); end
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        #1;
        checks++; if (sif.sram_we_n !== 1'b1 || freeze !== 1'b0) begin errors++;
            $display("FAIL rstmid_comb we_n=%b freeze=%b exp 1/0", sif.sram_we_n, freeze); end
        @(posedge clk); #1;
        checks++; if ({wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out} !== '0) begin errors++;
            $display("FAIL rstmid_outs got=%h exp=0", {wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out}); end
        checks++; if (fsm_state !== IDLE) begin errors++;
            $display("FAIL rstmid_state got=%0d exp=%0d", fsm_state, IDLE); end
        idle();
        rst = 1;
        last_load = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (sif.sram_we_n !== 1'b1 || freeze !== 1'b0 || sif.sram_addr !== '0 || fsm_state !== IDLE) begin
                errors++; $display("FAIL rstmid_quiet i=%0d we_n=%b freeze=%b addr=%h state=%0d", i,
                                   sif.sram_we_n, freeze, sif.sram_addr, fsm_state); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_w1();
        logic [31:0] a, v;
        a = 32'd1024 + 32'h0008_0000;
        v = $urandom;
        w1_mem_w_en_in = 1; w1_alu_res_in = a; w1_val_Rm_in = v; w1_dest_in = 4'd1;
        @(negedge clk);
        checks++; if (sif1.sram_addr !== 18'd0 || sif1.sram_wdata !== v[15:0] || sif1.sram_we_n !== 1'b0 || w1_freeze !== 1'b1) begin
            errors++; $display("FAIL w1_store_k0 got=%h/%h/%b/%b exp=0/%h/0/1", sif1.sram_addr, sif1.sram_wdata,
                               sif1.sram_we_n, w1_freeze, v[15:0]); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (sif1.sram_addr !== 18'd1 || sif1.sram_wdata !== v[31:16] || sif1.sram_we_n !== 1'b0 || w1_freeze !== 1'b0) begin
            errors++; $display("FAIL w1_store_k1 got=%h/%h/%b/%b exp=1/%h/0/0", sif1.sram_addr, sif1.sram_wdata,
                               sif1.sram_we_n, w1_freeze, v[31:16]); end
        @(posedge clk); #1;
        w1_mem_w_en_in = 0; w1_mem_r_en_in = 1; w1_wb_en_in = 1; w1_dest_in = 4'd5; w1_val_Rm_in = '0;
        @(negedge clk);
        checks++; if (sif1.sram_addr !== 18'd0 || sif1.sram_we_n !== 1'b1 || w1_freeze !== 1'b1) begin
            errors++; $display("FAIL w1_load_k0 got=%h/%b/%b exp=0/1/1", sif1.sram_addr, sif1.sram_we_n, w1_freeze); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (sif1.sram_addr !== 18'd1 || w1_freeze !== 1'b0) begin
            errors++; $display("FAIL w1_load_k1 got=%h/%b exp=1/0", sif1.sram_addr, w1_freeze); end
        @(posedge clk); #1;
        checks++; if (w1_mem_data_out !== v || w1_dest_out !== 4'd5 || w1_mem_r_en_out !== 1'b1 || w1_alu_res_out !== a) begin
            errors++; $display("FAIL w1_load_wb got=%h/%h/%b/%h exp=%h/5/1/%h", w1_mem_data_out, w1_dest_out,
                               w1_mem_r_en_out, w1_alu_res_out, v, a); end
        idle_w1();
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_alu_op();
        test_store();
        test_load();
        test_back_to_back();
        test_conflict();
        test_reset_mid();
        test_w1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits directly downstream of the execute stage, behind the EX/MEM pipeline register. It turns each load/store into two 16-bit accesses on an external SRAM, paced by a configurable wait-state counter. While an access is in flight it drives `freeze` to stall everything upstream. It also contains the MEM/WB pipeline register, so its outputs feed the write-back stage directly.

## Interface
Parameters:
- `REGISTER_LEN`, 32: data word width.
- `REG_ADDRESS_LEN`, 4: destination register index width.
- `SRAM_ADDR_WIDTH`, 18: SRAM halfword address width.
- `SRAM_DATA_WIDTH`, 16: SRAM data width; fixed at `REGISTER_LEN`/2.
- `WAIT_CYCLES`, 3: cycles each halfword access is held; ≥1.
- `DATA_BASE`, 1024: byte address mapped to SRAM halfword 0.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-low.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`  in  1  control from EX/MEM.
- `alu_res_in`  in  `REGISTER_LEN`  byte address, or ALU result for non-memory ops.
- `val_Rm_in`  in  `REGISTER_LEN`  store data.
- `dest_in`  in  `REG_ADDRESS_LEN`  destination register.
- `freeze`  out  1  stall request to PC, IF/ID, ID/EX and EX/MEM registers.
- `sram_addr`  out  `SRAM_ADDR_WIDTH`  halfword address.
- `sram_wdata`  out  `SRAM_DATA_WIDTH`  write data.
- `sram_rdata`  in  `SRAM_DATA_WIDTH`  read data; valid while address is held.
- `sram_we_n`  out  1  write strobe, active-low.
- `wb_en_out`, `mem_r_en_out`  out  1  registered control to WB.
- `alu_res_out`  out  `REGISTER_LEN`  registered ALU result.
- `mem_data_out`  out  `REGISTER_LEN`  registered load data.
- `dest_out`  out  `REG_ADDRESS_LEN`  registered destination.

## Operation
- Request = `mem_r_en_in | mem_w_en_in`. If both are high, the op is a write; `mem_data_out` is not updated.
- FSM states:
  - IDLE to LOW on a request.
  - LOW to HIGH after `WAIT_CYCLES`.
  - HIGH to IDLE after `WAIT_CYCLES`.
  - The cycle a request is first seen in IDLE counts as access cycle k=0, LOW phase.
- Access cycles k = 0 … 2·`WAIT_CYCLES`−1. LOW phase for k < W, HIGH phase otherwise.
- At k=0 the stage latches address, store data and op. Cycles k≥1 use the latched copy; k=0 drives directly from the inputs.
- Address: `off = alu_res_in − DATA_BASE`, `sram_addr = {off[SRAM_ADDR_WIDTH:2], phase}` with LOW=0, HIGH=1. Bits [1:0] are ignored. Upper bits are dropped, so addresses wrap modulo SRAM size.
- Write: `sram_wdata` = data[15:0] in LOW and data[31:16] in HIGH. `sram_we_n` = 0 for every cycle of both phases.
- Read: `sram_we_n` = 1. `sram_rdata` is sampled into a low-half holding register at the end of k=W−1. At the end of k=2W−1, `{sram_rdata, low_half}` is loaded into `mem_data_out`.
- `freeze` (combinational) = 1 from k=0 through k=2W−2; it is 0 at the completion cycle k=2W−1 and at all times in IDLE without a request.
- MEM/WB register: whenever `freeze`=0, it loads `wb_en`, `mem_r_en`, `alu_res` and `dest` from the inputs. It holds while `freeze`=1. `mem_data_out` changes only on read completion.
- Non-memory ops: no FSM activity, `sram_we_n`=1, `sram_addr`/`sram_wdata` = 0.

## Timing
- Memory op occupies 2·W cycles. `freeze` is high for 2·W−1 of them. WB outputs update at the edge ending k=2W−1.
- Non-memory op: WB outputs update one edge after the inputs are presented.
- Back-to-back memory ops: the FSM is in IDLE the cycle after completion, and the next request starts at k=0 there. There is no bubble cycle.
- Reset (`rst`=0 at an edge): state IDLE, counter 0, and all registered outputs 0. While `rst`=0, `freeze`=0 and `sram_we_n`=1 combinationally. Reset mid-access aborts it with no completion.
- W=1: LOW and HIGH are one cycle each, and `freeze` is high for k=0 only.

## Structure
- Shared defines header: `REGISTER_LEN`, `ADDRESS_LEN`, `REG_ADDRESS_LEN`, `SRAM_ADDR_WIDTH`, `SRAM_DATA_WIDTH`, `DATA_BASE`, and the FSM state encodings.
- Sub-module `sram_controller`: FSM, wait counter, request latch, low-half register, SRAM pins, `freeze` and a `done` pulse.
- `mem_stage`: wraps `sram_controller` and the MEM/WB register.

## Test plan
All scenarios use W=3 and DATA_BASE=1024 unless stated.
- **Store:** `mem_w_en`=1, `alu_res`=1032, `val_Rm`=0xDEADBEEF.
  - k0–2: `sram_addr`=4, `sram_wdata`=0xBEEF, `sram_we_n`=0.
  - k3–5: `sram_addr`=5, `sram_wdata`=0xDEAD.
  - `freeze` is high k0–4 and low at k5.
- **Load:** read of 1032 against the SRAM model holding the store above → after the k5 edge, `mem_data_out`=0xDEADBEEF, `mem_r_en_out`=1, `dest_out`=`dest_in`.
- **ALU op:** `wb_en`=1, `alu_res`=7, `dest`=3 → `freeze` never rises, `sram_we_n`=1, `alu_res_out`=7 and `dest_out`=3 one edge later.
- **Back-to-back and conflict:** load then store with no gap → the second access starts the cycle after the first completes. Both enables high → write pulses occur and `mem_data_out` is unchanged.
- **Reset:** `rst`=0 at store cycle k=2 → `sram_we_n`=1 and `freeze`=0 immediately. After the edge, all outputs are 0 and the FSM is IDLE. Releasing reset with no request causes no SRAM activity.
- **W=1:** store completes in 2 cycles with `freeze` high for 1 cycle. Address 1024+2^19 wraps to `sram_addr` 0/1.
